// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state set, the double-dabble adjust constants and a width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(w * log10(2)) using log10(2) ~= 0.30103
  function automatic int digits_for_width(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer and the BCD converter.
// The producer side uses the master modport, the converter uses slave.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  localparam int NW = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [NW-1:0]         out_ndigits;
  logic                  out_ovf;

  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndigits, out_ovf
  );

  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, out_ndigits, out_ovf
  );

endinterface

// File: rtl/bin2bcd_seq_step.sv
// One double-dabble iteration: add-3 adjust on every digit, then shift in one bit.
// The bit falling off the top digit is reported as carry.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                carry
);

  logic [4*DIGITS-1:0] adj;

  // Digits are adjusted independently; the add never carries into the next digit
  always_comb begin
    adj = bcd_in;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] >= BCD_ADJ_THRESH)
        adj[4*k +: 4] = bcd_in[4*k +: 4] + BCD_ADJ_ADD;
    end
  end

  assign {carry, bcd_out} = {adj, bit_in};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock.
// Returns DIGITS digits, a significant-digit count and an overflow flag.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  generate
    if (WIDTH < 1 || DIGITS < 1 || digits_for_width(WIDTH) < 1) begin : g_bad_params
      $error("bin2bcd_seq: WIDTH and DIGITS must both be >= 1");
    end
  endgenerate

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] bcd_sr;
  logic                ovf_sr;
  logic [4*DIGITS-1:0] bcd_q;
  logic [NW-1:0]       nd_q;
  logic                ovf_q;

  logic [4*DIGITS-1:0] step_bcd;
  logic                step_carry;
  logic [NW-1:0]       step_nd;

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd_in  (bcd_sr),
    .bit_in  (bin_sr[WIDTH-1]),
    .bcd_out (step_bcd),
    .carry   (step_carry)
  );

  // Digit count of the value about to be registered; zero still shows one digit
  always_comb begin
    step_nd = NW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (step_bcd[4*k +: 4] != 4'd0)
        step_nd = NW'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
      ovf_sr <= 1'b0;
      bcd_q  <= '0;
      nd_q   <= NW'(1);
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            bin_sr <= bus.in_bin;
            bcd_sr <= '0;
            ovf_sr <= 1'b0;
            cnt    <= CW'(WIDTH);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_sr <= step_bcd;
          bin_sr <= bin_sr << 1;
          ovf_sr <= ovf_sr | step_carry;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q <= step_bcd;
            nd_q  <= step_nd;
            ovf_q <= ovf_sr | step_carry;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.out_bcd     = bcd_q;
  assign bus.out_ndigits = nd_q;
  assign bus.out_ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: three configurations (8/3, 16/5, 8/2) checked
// against an arithmetic reference of value mod 10^DIGITS.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        iv;
  logic        ordy;
  logic [15:0] bin;
  int          sel;

  int errors;
  int checks;

  logic        c_rdy;
  logic        c_vld;
  logic [19:0] c_bcd;
  logic [2:0]  c_nd;
  logic        c_ovf;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if_a ();
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if_b ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) if_c ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.in_valid  = iv && (sel == 0);
  assign if_b.in_valid  = iv && (sel == 1);
  assign if_c.in_valid  = iv && (sel == 2);
  assign if_a.in_bin    = bin[7:0];
  assign if_b.in_bin    = bin;
  assign if_c.in_bin    = bin[7:0];
  assign if_a.out_ready = ordy && (sel == 0);
  assign if_b.out_ready = ordy && (sel == 1);
  assign if_c.out_ready = ordy && (sel == 2);

  always_comb begin
    c_rdy = 1'b0;
    c_vld = 1'b0;
    c_bcd = '0;
    c_nd  = '0;
    c_ovf = 1'b0;
    case (sel)
      0: begin
        c_rdy = if_a.in_ready; c_vld = if_a.out_valid; c_bcd = 20'(if_a.out_bcd);
        c_nd = 3'(if_a.out_ndigits); c_ovf = if_a.out_ovf;
      end
      1: begin
        c_rdy = if_b.in_ready; c_vld = if_b.out_valid; c_bcd = 20'(if_b.out_bcd);
        c_nd = 3'(if_b.out_ndigits); c_ovf = if_b.out_ovf;
      end
      2: begin
        c_rdy = if_c.in_ready; c_vld = if_c.out_valid; c_bcd = 20'(if_c.out_bcd);
        c_nd = 3'(if_c.out_ndigits); c_ovf = if_c.out_ovf;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: keep value mod 10^digits, count its decimal digits, flag anything lost
  task automatic ref_model(input int v, input int digits, output logic [19:0] bcd,
                           output logic [2:0] nd, output logic ovf);
    int p;
    int m;
    int t;
    int n;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    ovf = (v >= p);
    m = v % p;
    bcd = '0;
    t = m;
    for (int k = 0; k < digits; k++) begin
      bcd[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    n = 0;
    t = m;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    if (n == 0) n = 1;
    nd = 3'(n);
  endtask

  task automatic run(input int s, input logic [15:0] v, input int bp,
                     output logic [19:0] bcd, output logic [2:0] nd,
                     output logic ovf, output int lat);
    int w;
    sel = s;
    #1;
    w = 0;
    while (!c_rdy && w < 100) begin
      @(posedge clk); #1; w++;
    end
    bin = v;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv  = 1'b0;
    lat = 0;
    while (!c_vld && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!c_vld) lat = -1;
    bcd = c_bcd;
    nd  = c_nd;
    ovf = c_ovf;
    repeat (bp) begin
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (c_rdy !== 1'b1 || c_vld !== 1'b0 || c_bcd !== 20'h0 || c_nd !== 3'd1 || c_ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state sel=%0d: got rdy=%b vld=%b bcd=%h nd=%0d ovf=%b, need 1 0 0 1 0",
                 s, c_rdy, c_vld, c_bcd, c_nd, c_ovf);
      end
    end
  endtask

  task automatic test_small_values();
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
    int          lat;
    run(0, 16'd0, 0, bcd, nd, ovf, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("[TB] FAIL zero_latency: got %0d need 8", lat); end
    checks++;
    if (bcd !== 20'h000 || nd !== 3'd1 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_value: got bcd=%h nd=%0d ovf=%b need 000 1 0", bcd, nd, ovf);
    end
    run(0, 16'd255, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h255 || nd !== 3'd3 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL value_255: got bcd=%h nd=%0d ovf=%b need 255 3 0", bcd, nd, ovf);
    end
    run(0, 16'd7, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h007 || nd !== 3'd1 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL value_7: got bcd=%h nd=%0d ovf=%b need 007 1 0", bcd, nd, ovf);
    end
  endtask

  task automatic test_wide();
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
    int          lat;
    run(1, 16'hFFFF, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h65535 || nd !== 3'd5 || ovf !== 1'b0 || lat !== 16) begin
      errors++; $display("[TB] FAIL wide_ffff: got bcd=%h nd=%0d ovf=%b lat=%0d need 65535 5 0 16", bcd, nd, ovf, lat);
    end
    run(1, 16'd1000, 1, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h01000 || nd !== 3'd4 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL wide_1000: got bcd=%h nd=%0d ovf=%b need 01000 4 0", bcd, nd, ovf);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
    int          lat;
    run(2, 16'd200, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h00 || nd !== 3'd1 || ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_200: got bcd=%h nd=%0d ovf=%b need 00 1 1", bcd, nd, ovf);
    end
    run(2, 16'd123, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h23 || nd !== 3'd2 || ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_123: got bcd=%h nd=%0d ovf=%b need 23 2 1", bcd, nd, ovf);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 0;
    #1;
    bin = 16'd93;
    iv  = 1'b1;
    @(posedge clk); #1;
    bin = 16'd55;
    lat = 0;
    while (!c_vld && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 8 || c_bcd !== 20'h093) begin
      errors++; $display("[TB] FAIL bp_first: got lat=%0d bcd=%h need 8 093", lat, c_bcd);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (c_vld !== 1'b1 || c_rdy !== 1'b0 || c_bcd !== 20'h093 || c_nd !== 3'd2) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got vld=%b rdy=%b bcd=%h nd=%0d need 1 0 093 2", i, c_vld, c_rdy, c_bcd, c_nd);
      end
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    checks++;
    if (c_rdy !== 1'b1 || c_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: got rdy=%b vld=%b need 1 0", c_rdy, c_vld);
    end
    @(posedge clk); #1;
    iv = 1'b0;
    checks++;
    if (c_rdy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_accept_next: got rdy=%b need 0", c_rdy);
    end
    lat = 0;
    while (!c_vld && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 8 || c_bcd !== 20'h055) begin
      errors++; $display("[TB] FAIL bp_second: got lat=%0d bcd=%h need 8 055", lat, c_bcd);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
    int          lat;
    int          seen;
    sel = 0;
    #1;
    bin = 16'd150;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (c_vld !== 1'b0 || c_rdy !== 1'b1 || c_bcd !== 20'h0) begin
      errors++; $display("[TB] FAIL abort_reset: got vld=%b rdy=%b bcd=%h need 0 1 000", c_vld, c_rdy, c_bcd);
    end
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (c_vld !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("[TB] FAIL abort_no_output: got %0d valid cycles need 0", seen);
    end
    run(0, 16'd42, 0, bcd, nd, ovf, lat);
    checks++;
    if (bcd !== 20'h042 || nd !== 3'd2 || ovf !== 1'b0 || lat !== 8) begin
      errors++; $display("[TB] FAIL abort_then_42: got bcd=%h nd=%0d ovf=%b lat=%0d need 042 2 0 8", bcd, nd, ovf, lat);
    end
  endtask

  task automatic test_random();
    logic [19:0] bcd, ebcd;
    logic [2:0]  nd, end_;
    logic        ovf, eovf;
    int          lat;
    int          v;
    int          digs;
    for (int s = 0; s < 3; s++) begin
      digs = (s == 0) ? 3 : (s == 1) ? 5 : 2;
      for (int i = 0; i < 30; i++) begin
        v = (s == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 255));
        run(s, 16'(v), int'($urandom_range(0, 3)), bcd, nd, ovf, lat);
        ref_model(v, digs, ebcd, end_, eovf);
        checks++;
        if (bcd !== ebcd || nd !== end_ || ovf !== eovf || lat !== ((s == 1) ? 16 : 8)) begin
          errors++;
          $display("[TB] FAIL random sel=%0d v=%0d: got bcd=%h nd=%0d ovf=%b lat=%0d need %h %0d %b",
                   s, v, bcd, nd, ovf, lat, ebcd, end_, eovf);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    bin  = '0;
    sel  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_small_values();
    test_wide();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
